// File: rtl/mem_test_master_if.sv
// Avalon-MM master/slave bundle used by mem_test_master.
// The byteenable width follows DATA_W/8.
interface mem_test_master_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   avm_address;
  logic                avm_chipselect;
  logic                avm_write;
  logic                avm_read;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic [DATA_W-1:0]   avm_writedata;
  logic [DATA_W-1:0]   avm_readdata;
  logic                avm_waitrequest;
  logic                avm_readdatavalid;

  modport master (
    output avm_address, avm_chipselect, avm_write, avm_read, avm_byteenable, avm_writedata,
    input  avm_readdata, avm_waitrequest, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_chipselect, avm_write, avm_read, avm_byteenable, avm_writedata,
    output avm_readdata, avm_waitrequest, avm_readdatavalid
  );
endinterface

// File: rtl/mem_test_master.sv
// Memory test master: writes P(a)=seed+a over [first_addr,last_addr], reads back and counts mismatches.
// Define MEM_TEST_MASTER_INVERT_PASS_EN to add a second write/read pass using ~P(a).
module mem_test_master #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     first_addr,
  input  logic [ADDR_W-1:0]     last_addr,
  input  logic [DATA_W-1:0]     seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           err_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  mem_test_master_if.master     avm_m
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    RWAIT = 3'd3,
    FIN   = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1'b1);

  function automatic logic [DATA_W-1:0] pattern(input logic [DATA_W-1:0] s,
                                                input logic [ADDR_W-1:0] a);
    pattern = s + DATA_W'(a);
  endfunction

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W-1:0]   r_first;
  logic [ADDR_W-1:0]   r_last;
  logic [DATA_W-1:0]   r_seed;
  logic [15:0]         r_err;
  logic [ADDR_W-1:0]   r_ferr;
  logic                r_pass;
  logic                r_busy;
  logic                r_done;
  logic                r_cs;
  logic                r_wr;
  logic                r_rd;
  logic [DATA_W-1:0]   r_wdata;

  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [ADDR_W-1:0]   w_first_nxt;
  logic [ADDR_W-1:0]   w_last_nxt;
  logic [DATA_W-1:0]   w_seed_nxt;
  logic [15:0]         w_err_nxt;
  logic [ADDR_W-1:0]   w_ferr_nxt;
  logic                w_pass_nxt;
  logic [DATA_W-1:0]   w_expect;
  logic [DATA_W-1:0]   w_wdata_nxt;

`ifdef MEM_TEST_MASTER_INVERT_PASS_EN
  logic                r_second;
  logic                w_second_nxt;

  // The second pass stores and expects the bitwise inverse of the pattern.
  assign w_expect    = pattern(r_seed, r_addr) ^ {DATA_W{r_second}};
  assign w_wdata_nxt = pattern(w_seed_nxt, w_addr_nxt) ^ {DATA_W{w_second_nxt}};
`else
  assign w_expect    = pattern(r_seed, r_addr);
  assign w_wdata_nxt = pattern(w_seed_nxt, w_addr_nxt);
`endif

  assign busy                 = r_busy;
  assign done                 = r_done;
  assign pass                 = r_pass;
  assign err_count            = r_err;
  assign first_err_addr       = r_ferr;
  assign avm_m.avm_address    = r_addr;
  assign avm_m.avm_chipselect = r_cs;
  assign avm_m.avm_write      = r_wr;
  assign avm_m.avm_read       = r_rd;
  assign avm_m.avm_writedata  = r_wdata;
  assign avm_m.avm_byteenable = {(DATA_W/8){1'b1}};

  // Next-state, address walk and result bookkeeping.
  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    w_first_nxt = r_first;
    w_last_nxt  = r_last;
    w_seed_nxt  = r_seed;
    w_err_nxt   = r_err;
    w_ferr_nxt  = r_ferr;
    w_pass_nxt  = r_pass;
`ifdef MEM_TEST_MASTER_INVERT_PASS_EN
    w_second_nxt = r_second;
`endif
    case (r_state)
      IDLE: begin
        if (start) begin
          w_first_nxt = first_addr;
          w_last_nxt  = last_addr;
          w_seed_nxt  = seed;
          w_err_nxt   = 16'd0;
          w_ferr_nxt  = {ADDR_W{1'b0}};
          w_pass_nxt  = 1'b0;
          w_addr_nxt  = first_addr;
`ifdef MEM_TEST_MASTER_INVERT_PASS_EN
          w_second_nxt = 1'b0;
`endif
          // An inverted range finishes immediately with pass left low.
          if (first_addr > last_addr) begin
            w_state_nxt = FIN;
          end else begin
            w_state_nxt = WR;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      WR: begin
        if (!avm_m.avm_waitrequest) begin
          if (r_addr == r_last) begin
            w_state_nxt = RD;
            w_addr_nxt  = r_first;
          end else begin
            w_state_nxt = WR;
            w_addr_nxt  = r_addr + ADDR_ONE;
          end
        end else begin
          w_state_nxt = WR;
        end
      end
      RD: begin
        if (!avm_m.avm_waitrequest) begin
          w_state_nxt = RWAIT;
        end else begin
          w_state_nxt = RD;
        end
      end
      RWAIT: begin
        if (avm_m.avm_readdatavalid) begin
          if (avm_m.avm_readdata != w_expect) begin
            if (r_err == 16'd0) begin
              w_ferr_nxt = r_addr;
            end else begin
              w_ferr_nxt = r_ferr;
            end
            if (r_err != 16'hFFFF) begin
              w_err_nxt = r_err + 16'd1;
            end else begin
              w_err_nxt = r_err;
            end
          end else begin
            w_err_nxt = r_err;
          end
          if (r_addr == r_last) begin
`ifdef MEM_TEST_MASTER_INVERT_PASS_EN
            if (!r_second) begin
              w_second_nxt = 1'b1;
              w_state_nxt  = WR;
              w_addr_nxt   = r_first;
            end else begin
              w_state_nxt = FIN;
              w_pass_nxt  = (w_err_nxt == 16'd0);
            end
`else
            w_state_nxt = FIN;
            w_pass_nxt  = (w_err_nxt == 16'd0);
`endif
          end else begin
            w_state_nxt = RD;
            w_addr_nxt  = r_addr + ADDR_ONE;
          end
        end else begin
          w_state_nxt = RWAIT;
        end
      end
      FIN: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State register; bus strobes and status are registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_addr  <= {ADDR_W{1'b0}};
      r_first <= {ADDR_W{1'b0}};
      r_last  <= {ADDR_W{1'b0}};
      r_seed  <= {DATA_W{1'b0}};
      r_err   <= 16'd0;
      r_ferr  <= {ADDR_W{1'b0}};
      r_pass  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cs    <= 1'b0;
      r_wr    <= 1'b0;
      r_rd    <= 1'b0;
      r_wdata <= {DATA_W{1'b0}};
`ifdef MEM_TEST_MASTER_INVERT_PASS_EN
      r_second <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_first <= w_first_nxt;
      r_last  <= w_last_nxt;
      r_seed  <= w_seed_nxt;
      r_err   <= w_err_nxt;
      r_ferr  <= w_ferr_nxt;
      r_pass  <= w_pass_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      r_done  <= (w_state_nxt == FIN);
      r_cs    <= (w_state_nxt == WR) || (w_state_nxt == RD);
      r_wr    <= (w_state_nxt == WR);
      r_rd    <= (w_state_nxt == RD);
      r_wdata <= (w_state_nxt == WR) ? w_wdata_nxt : r_wdata;
`ifdef MEM_TEST_MASTER_INVERT_PASS_EN
      r_second <= w_second_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_mem_test_master.sv
// Self-checking bench for mem_test_master: memory slave model with stalls, latency and corruption,
// plus a range-level reference model of the expected writes and mismatch results.
module tb_mem_test_master;
  localparam int AW    = 14;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;
`ifdef MEM_TEST_MASTER_INVERT_PASS_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] first_addr;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] seed;
  logic          busy;
  logic          done;
  logic          pass;
  logic [15:0]   err_count;
  logic [AW-1:0] first_err_addr;

  always #5 clk = ~clk;

  mem_test_master_if #(.ADDR_W(AW), .DATA_W(DW)) avm_bus ();

  mem_test_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .first_addr     (first_addr),
    .last_addr      (last_addr),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .avm_m          (avm_bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0]    mem     [DEPTH];
  bit               corrupt [DEPTH];
  logic [AW+DW-1:0] wr_log  [$];
  int               wait_n     = 0;
  int               rd_lat     = 1;
  int               wait_cnt   = 0;
  int               rd_cnt     = 0;
  int               rd_accepts = 0;
  int               viol       = 0;
  int               cs_cycles  = 0;
  logic [AW-1:0]    rd_addr;
  bit               prev_stall = 1'b0;
  logic [AW+DW+2:0] prev_snap;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Slave model and protocol monitor, evaluated on the falling edge
  initial begin
    logic [AW+DW+2:0] snap;
    avm_bus.avm_waitrequest   = 1'b0;
    avm_bus.avm_readdatavalid = 1'b0;
    avm_bus.avm_readdata      = '0;
    forever begin
      @(negedge clk);
      snap = {avm_bus.avm_chipselect, avm_bus.avm_write, avm_bus.avm_read,
              avm_bus.avm_address, avm_bus.avm_writedata};
      if (prev_stall && (snap !== prev_snap)) viol++;
      if (avm_bus.avm_write && avm_bus.avm_read) viol++;
      if (avm_bus.avm_chipselect) cs_cycles++;
      avm_bus.avm_readdatavalid = 1'b0;
      if (rd_cnt > 0) begin
        rd_cnt--;
        if (rd_cnt == 0) begin
          avm_bus.avm_readdatavalid = 1'b1;
          avm_bus.avm_readdata = mem[rd_addr] ^ (corrupt[rd_addr] ? 32'h1 : 32'h0);
        end
      end
      if (avm_bus.avm_chipselect && (avm_bus.avm_write || avm_bus.avm_read)) begin
        if (wait_cnt < wait_n) begin
          avm_bus.avm_waitrequest = 1'b1;
          wait_cnt++;
        end else begin
          avm_bus.avm_waitrequest = 1'b0;
          wait_cnt = 0;
          if (avm_bus.avm_write) begin
            mem[avm_bus.avm_address] = avm_bus.avm_writedata;
            wr_log.push_back({avm_bus.avm_address, avm_bus.avm_writedata});
          end else begin
            rd_addr = avm_bus.avm_address;
            rd_cnt  = rd_lat;
            rd_accepts++;
          end
        end
      end else begin
        avm_bus.avm_waitrequest = 1'b0;
        wait_cnt = 0;
      end
      prev_stall = avm_bus.avm_chipselect && avm_bus.avm_waitrequest;
      prev_snap  = snap;
    end
  end

  task automatic clear_corrupt();
    for (int i = 0; i < DEPTH; i++) corrupt[i] = 1'b0;
  endtask

  task automatic run_test(input string tag, input int f, input int l,
                          input logic [DW-1:0] s, input int wn);
    logic [AW+DW-1:0] exp_wr[$];
    logic [AW+DW-1:0] got;
    int exp_err;
    int exp_ferr;
    bit found;
    int cyc;
    int viol0;
    int cs0;
    logic [DW-1:0] d;
    exp_err = 0;
    exp_ferr = 0;
    found = 1'b0;
    if (f <= l) begin
      for (int p = 0; p < NPASS; p++) begin
        for (int a = f; a <= l; a++) begin
          d = s + DW'(a);
          if (p == 1) d = ~d;
          exp_wr.push_back({AW'(a), d});
          if (corrupt[a]) begin
            if (!found) begin
              exp_ferr = a;
              found = 1'b1;
            end
            exp_err++;
          end
        end
      end
    end
    wait_n = wn;
    wr_log.delete();
    rd_accepts = 0;
    viol0 = viol;
    cs0 = cs_cycles;
    @(negedge clk);
    first_addr = AW'(f);
    last_addr  = AW'(l);
    seed       = s;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, ".busy_after_start"}, busy, 1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, ".done_seen"}, done, 1);
    if (f > l) check({tag, ".done_latency"}, cyc, 0);
    check({tag, ".pass"}, pass, (exp_err == 0 && f <= l) ? 1 : 0);
    check({tag, ".err_count"}, err_count, exp_err);
    if (exp_err > 0) check({tag, ".first_err_addr"}, first_err_addr, exp_ferr);
    check({tag, ".n_writes"}, wr_log.size(), exp_wr.size());
    for (int i = 0; i < exp_wr.size(); i++) begin
      got = (i < wr_log.size()) ? wr_log[i] : 'x;
      check({tag, ".write"}, got, exp_wr[i]);
    end
    check({tag, ".n_reads"}, rd_accepts, (f <= l) ? NPASS * (l - f + 1) : 0);
    check({tag, ".protocol"}, viol - viol0, 0);
    if (f > l) check({tag, ".no_chipselect"}, cs_cycles - cs0, 0);
    @(negedge clk);
    check({tag, ".done_pulse"}, done, 0);
    check({tag, ".busy_cleared"}, busy, 0);
  endtask

  initial begin
    int cyc;
    int f;
    int l;
    reset = 1'b1;
    start = 1'b0;
    first_addr = '0;
    last_addr = '0;
    seed = '0;
    clear_corrupt();
    repeat (3) @(negedge clk);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.pass", pass, 0);
    check("rst.err_count", err_count, 0);
    check("rst.first_err_addr", first_err_addr, 0);
    check("rst.address", avm_bus.avm_address, 0);
    check("rst.writedata", avm_bus.avm_writedata, 0);
    check("rst.strobes", {avm_bus.avm_chipselect, avm_bus.avm_write, avm_bus.avm_read}, 0);
    check("rst.byteenable", avm_bus.avm_byteenable, 4'hF);
    reset = 1'b0;

    run_test("basic", 0, 3, 32'h100, 0);
    corrupt[2] = 1'b1;
    run_test("corrupt2", 0, 3, 32'h100, 0);
    clear_corrupt();
    run_test("stall3", 0, 3, 32'h100, 3);
    run_test("empty", 5, 4, 32'h55, 0);
    run_test("inv", 0, 1, 32'h0, 0);
    run_test("top_edge", DEPTH - 4, DEPTH - 1, 32'hFFFF_FFFE, 1);

    // Reset while waiting for read data; the late response must be ignored
    wait_n = 0;
    rd_lat = 2;
    for (int a = 0; a < 4; a++) corrupt[a] = 1'b1;
    rd_accepts = 0;
    @(negedge clk);
    first_addr = '0;
    last_addr = AW'(3);
    seed = 32'h1234;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(busy && !avm_bus.avm_chipselect && rd_accepts > 0) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("rwait_reset.reached_rwait", (cyc < 200) ? 1 : 0, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rwait_reset.strobes", {avm_bus.avm_chipselect, avm_bus.avm_write, avm_bus.avm_read}, 0);
    check("rwait_reset.busy", busy, 0);
    check("rwait_reset.address", avm_bus.avm_address, 0);
    check("rwait_reset.writedata", avm_bus.avm_writedata, 0);
    repeat (2) @(negedge clk);
    check("rwait_reset.err_count", err_count, 0);
    check("rwait_reset.idle_busy", busy, 0);
    check("rwait_reset.idle_done", done, 0);
    clear_corrupt();
    rd_lat = 1;
    run_test("after_reset", 0, 2, 32'hA5A5_0000, 0);

    for (int r = 0; r < 8; r++) begin
      clear_corrupt();
      f = $urandom_range(0, 60);
      l = f + $urandom_range(0, 10);
      for (int a = f; a <= l; a++) corrupt[a] = ($urandom_range(0, 3) == 0);
      rd_lat = $urandom_range(1, 3);
      run_test($sformatf("rand%0d", r), f, l, $urandom, $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
